// File: rtl/i2c_slave_mem.sv
`default_nettype none
// ============================================================================
// i2c_slave_mem : I2C target with a 2**MEM_AW byte register memory
// Revision      : 1.0
// ============================================================================
module i2c_slave_mem #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         MEM_AW     = 8,
  parameter int         FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_stb,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam int DEPTH = 2 ** MEM_AW;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA through the whole input path.
  logic [1:0]       sync1_q, sync2_q, filt_q, prev_q;
  logic [CNT_W-1:0] cnt_q [2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {scl_i, sda_i};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic start_ev, stop_ev, scl_rise, scl_fall;

  assign scl_f    = filt_q[1];
  assign sda_f    = filt_q[0];
  assign scl_p    = prev_q[1];
  assign sda_p    = prev_q[0];
  assign start_ev = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_ev  = scl_f & scl_p & ~sda_p & sda_f;
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;

  state_t            state_q, state_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_stb_q, wr_stb_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              mack_q, mack_d;

  logic [7:0]        mem_q [DEPTH];
  logic              mem_we;
  logic [7:0]        rx_byte;
  logic [MEM_AW-1:0] ptr_inc;

  assign rx_byte = {shift_q[6:0], sda_f};
  assign ptr_inc = ptr_q + MEM_AW'(1);

  // Register file contents are intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mack_q    <= mack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mack_d    = mack_q;
    mem_we    = 1'b0;

    if (start_ev) begin
      state_d  = ST_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_ev) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA: begin
          if (bitcnt_q < 4'd8) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (state_q != ST_RDATA) shift_d = rx_byte;
            // The write commits on the rise that samples the last data bit.
            if (state_q == ST_WDATA && bitcnt_q == 4'd7) begin
              mem_we    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
              ptr_d     = ptr_inc;
            end
          end
        end
        ST_RDATA_ACK: mack_d = ~sda_f;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: begin
          if (bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          sda_oe_d = 1'b0;
          if (shift_q[0]) begin
            state_d  = ST_RDATA;
            shift_d  = mem_q[ptr_q];
            sda_oe_d = ~mem_q[ptr_q][7];
          end else begin
            state_d = ST_PTR;
          end
        end
        ST_PTR: begin
          if (bitcnt_q == 4'd8) begin
            ptr_d    = MEM_AW'(shift_q);
            state_d  = ST_PTR_ACK;
            sda_oe_d = 1'b1;
            bitcnt_d = '0;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          sda_oe_d = 1'b0;
          state_d  = ST_WDATA;
        end
        ST_WDATA: begin
          if (bitcnt_q == 4'd8) begin
            state_d  = ST_WDATA_ACK;
            sda_oe_d = 1'b1;
            bitcnt_d = '0;
          end
        end
        ST_RDATA: begin
          if (bitcnt_q == 4'd8) begin
            state_d  = ST_RDATA_ACK;
            sda_oe_d = 1'b0;
            bitcnt_d = '0;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        ST_RDATA_ACK: begin
          if (mack_q) begin
            ptr_d    = ptr_inc;
            shift_d  = mem_q[ptr_inc];
            sda_oe_d = ~mem_q[ptr_inc][7];
            state_d  = ST_RDATA;
          end else begin
            state_d = ST_IGNORE;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_mem.sv
`default_nettype none
// ============================================================================
// tb_i2c_slave_mem : directed bench driving an I2C master model against the target
// Revision         : 1.0
// ============================================================================
module tb_i2c_slave_mem;

  localparam int Q = 10;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       scl_m  = 1'b1;
  logic       sda_m  = 1'b1;
  logic       sda_oe, busy, wr_stb;
  logic [7:0] wr_addr, wr_data;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_mem #(
    .DEV_ADDR  (7'h50),
    .MEM_AW    (8),
    .FILTER_LEN(3)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .scl_i  (scl_m),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .busy   (busy),
    .wr_stb (wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int stb_cnt   = 0;
  int oe_cyc    = 0;
  int busy_cyc  = 0;
  logic [7:0] log_a [64];
  logic [7:0] log_d [64];

  always @(negedge clk) begin
    if (wr_stb) begin
      log_a[stb_cnt % 64] = wr_addr;
      log_d[stb_cnt % 64] = wr_data;
      stb_cnt++;
    end
    if (sda_oe) oe_cyc++;
    if (busy)   busy_cyc++;
  end

  typedef struct {
    logic [7:0]      dev;
    logic [7:0]      ptr;
    int              n;
    logic [2:0][7:0] d;
    bit              ack;
  } wvec_t;

  typedef struct {
    logic [7:0]      ptr;
    int              n;
    logic [2:0][7:0] d;
    logic [7:0]      nxt;
  } rvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hold(Q);
    scl_m = 1'b1; hold(Q);
    sda_m = 1'b0; hold(Q);
    scl_m = 1'b0; hold(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hold(Q);
    scl_m = 1'b1; hold(Q);
    sda_m = 1'b1; hold(Q);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b;    hold(Q);
    scl_m = 1'b1; hold(Q);
    s = sda_line; hold(Q);
    scl_m = 1'b0; hold(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, output bit ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(v[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input bit ack_m, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      v[i] = s;
    end
    bit_xfer(~ack_m, s);
  endtask

  initial begin
    wvec_t      wv [4];
    rvec_t      rv [3];
    int         base, oe0, busy0;
    bit         ack;
    logic [7:0] rd, ea;
    logic       s;

    wv[0] = '{dev:8'hA0, ptr:8'h10, n:3, d:{8'h33, 8'h22, 8'h11}, ack:1'b1};
    wv[1] = '{dev:8'hA0, ptr:8'hFF, n:2, d:{8'h00, 8'hBB, 8'hAA}, ack:1'b1};
    wv[2] = '{dev:8'hA4, ptr:8'h10, n:2, d:{8'h00, 8'h66, 8'h55}, ack:1'b0};
    wv[3] = '{dev:8'hA0, ptr:8'h05, n:1, d:{8'h00, 8'h00, 8'h12}, ack:1'b1};

    rv[0] = '{ptr:8'h10, n:3, d:{8'h33, 8'h22, 8'h11}, nxt:8'h33};
    rv[1] = '{ptr:8'hFF, n:2, d:{8'h00, 8'hBB, 8'hAA}, nxt:8'hBB};
    rv[2] = '{ptr:8'h05, n:1, d:{8'h00, 8'h00, 8'h12}, nxt:8'h12};

    hold(5);
    check("rst_sda_oe",  32'(sda_oe),  32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_wr_stb",  32'(wr_stb),  32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);
    resetn = 1'b1;
    hold(10);

    for (int t = 0; t < 4; t++) begin
      base  = stb_cnt;
      oe0   = oe_cyc;
      busy0 = busy_cyc;
      i2c_start();
      write_byte(wv[t].dev, ack);
      check("w_dev_ack", 32'(ack), 32'(wv[t].ack));
      check("w_busy", 32'(busy), 32'(wv[t].ack));
      write_byte(wv[t].ptr, ack);
      check("w_ptr_ack", 32'(ack), 32'(wv[t].ack));
      for (int i = 0; i < wv[t].n; i++) begin
        write_byte(wv[t].d[i], ack);
        check("w_data_ack", 32'(ack), 32'(wv[t].ack));
      end
      i2c_stop();
      hold(Q);
      check("w_busy_after_stop", 32'(busy), 32'h0);
      check("w_stb_count", 32'(stb_cnt - base), 32'(wv[t].ack ? wv[t].n : 0));
      if (wv[t].ack) begin
        for (int i = 0; i < wv[t].n; i++) begin
          ea = wv[t].ptr + 8'(i);
          check("w_log_addr", 32'(log_a[(base + i) % 64]), 32'(ea));
          check("w_log_data", 32'(log_d[(base + i) % 64]), 32'(wv[t].d[i]));
        end
      end else begin
        check("mismatch_sda_oe", 32'(oe_cyc - oe0), 32'h0);
        check("mismatch_busy", 32'(busy_cyc - busy0), 32'h0);
      end
    end

    for (int t = 0; t < 3; t++) begin
      i2c_start();
      write_byte(8'hA0, ack);
      check("r_wdev_ack", 32'(ack), 32'h1);
      write_byte(rv[t].ptr, ack);
      check("r_ptr_ack", 32'(ack), 32'h1);
      i2c_start();
      write_byte(8'hA1, ack);
      check("r_rdev_ack", 32'(ack), 32'h1);
      for (int i = 0; i < rv[t].n; i++) begin
        read_byte(i != rv[t].n - 1, rd);
        check("r_data", 32'(rd), 32'(rv[t].d[i]));
      end
      check("r_nack_sda_rel", 32'(sda_oe), 32'h0);
      check("r_nack_busy", 32'(busy), 32'h0);
      i2c_start();
      write_byte(8'hA1, ack);
      check("r_cont_ack", 32'(ack), 32'h1);
      read_byte(1'b0, rd);
      check("r_ptr_cont", 32'(rd), 32'(rv[t].nxt));
      i2c_stop();
      hold(Q);
    end

    // Early STOP in the middle of a data byte.
    base = stb_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("es_dev_ack", 32'(ack), 32'h1);
    write_byte(8'h20, ack);
    check("es_ptr_ack", 32'(ack), 32'h1);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    i2c_stop();
    hold(Q);
    check("es_no_write", 32'(stb_cnt - base), 32'h0);
    check("es_busy", 32'(busy), 32'h0);
    i2c_start();
    write_byte(8'hA0, ack);
    check("es_next_dev_ack", 32'(ack), 32'h1);
    write_byte(8'h30, ack);
    check("es_next_ptr_ack", 32'(ack), 32'h1);
    write_byte(8'h77, ack);
    check("es_next_data_ack", 32'(ack), 32'h1);
    i2c_stop();
    hold(Q);
    check("es_next_stb", 32'(stb_cnt - base), 32'h1);
    check("es_next_wr_addr", 32'(wr_addr), 32'h30);
    check("es_next_wr_data", 32'(wr_data), 32'h77);

    // Reset while the target is driving the MSB (0) of mem[0x05] = 0x12.
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rr_dev_ack", 32'(ack), 32'h1);
    check("rr_drive0", 32'(sda_oe), 32'h1);
    check("rr_busy_pre", 32'(busy), 32'h1);
    #1 resetn = 1'b0;
    #1;
    check("rr_sda_oe_async", 32'(sda_oe), 32'h0);
    check("rr_busy_async", 32'(busy), 32'h0);
    check("rr_wr_addr", 32'(wr_addr), 32'h0);
    hold(3);
    resetn = 1'b1;
    hold(5);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rr_after_ack", 32'(ack), 32'h1);
    read_byte(1'b0, rd);
    check("rr_after_ptr0", 32'(rd), 32'hBB);
    i2c_stop();
    hold(Q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
